// File: rtl/cpu_defs.sv
// Shared definitions for the divide unit: FSM encoding, iteration count and
// the HI/LO split of the 64-bit result.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int DIV_CYCLES = 32;

    // result = {hi = remainder, lo = quotient}
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, subtract the
// divisor from the widened remainder and keep the difference if it did not
// go negative.
module div_step
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // The shifted remainder needs one extra bit; since rem < divisor it is
    // always below 2*divisor, so a kept difference fits back in WIDTH bits.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction and restore select.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
        end else begin
            rem_o = shifted[WIDTH-1:0];
        end
        quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU for the execute stage. Radix-2 restoring divider on
// operand magnitudes with a sign fix-up; produces {hi = rem, lo = quo} and a
// combinational stall request for the hazard unit.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start
// BUSY  | iterating, cnt_q counts 0..WIDTH-1
// DONE  | result valid, ready high, pipeline advances
module div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_div
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   rem_nx, quo_nx;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (rem_nx),
        .quo_o     (quo_nx)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state, iteration and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        // 0x80000000 maps to itself, which is the correct unsigned magnitude.
        a_mag = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        b_mag = (signed_div && opb[WIDTH-1]) ? -opb : opb;

        // The fix-up is applied as the last iteration's result is registered,
        // so result_q already holds signed values in the DONE cycle.
        quo_fix = neg_quo_q ? -quo_nx : quo_nx;
        rem_fix = neg_rem_q ? -rem_nx : rem_nx;

        if (annul) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (opb == '0) begin
                            state_d  = DONE;
                            result_d = {opa, {WIDTH{1'b1}}};
                            ready_d  = 1'b1;
                        end else begin
                            state_d   = BUSY;
                            cnt_d     = '0;
                            rem_d     = '0;
                            quo_d     = a_mag;
                            dvsr_d    = b_mag;
                            neg_quo_d = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                            neg_rem_d = signed_div & opa[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign stall_div = start & ~annul & (state_q != DONE) & ~rst;
    assign result    = result_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    import cpu_defs::*;

    localparam int W = DIV_CYCLES;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stall_div;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_div  (stall_div)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Runs one divide from IDLE (or from a DONE cycle when after_done is set),
    // returning in the DONE cycle with start still high.
    task automatic run_div(input string nm, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi,
                           input logic [31:0] elo, input int ecyc, input bit after_done);
        int cyc;
        int stalls;
        bit seen;
        signed_div = sg;
        opa        = a;
        opb        = b;
        start      = 1'b1;
        annul      = 1'b0;
        #1;
        if (after_done) begin
            chk({nm, " stall in DONE"}, 64'(stall_div), 64'd0);
            step();
        end
        cyc    = 0;
        stalls = 0;
        seen   = 0;
        while (!seen && cyc <= ecyc + 8) begin
            if (ready) begin
                seen = 1;
            end else begin
                if (stall_div) stalls++;
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (cyc == 5) begin
                    opa = ~a;
                    opb = b ^ 32'h0000_1234;
                end
                #1;
            end
        end
        chk({nm, " ready seen"}, 64'(seen), 64'd1);
        chk({nm, " ready cycle"}, 64'(cyc), 64'(ecyc));
        chk({nm, " hi"}, 64'(result[HI_MSB:HI_LSB]), 64'(ehi));
        chk({nm, " lo"}, 64'(result[LO_MSB:LO_LSB]), 64'(elo));
        chk({nm, " stall cycles"}, 64'(stalls), 64'(ecyc));
        chk({nm, " stall at done"}, 64'(stall_div), 64'd0);
    endtask

    initial begin
        int rdy_cnt;
        logic [63:0] held;

        vecs[0]  = '{"divu 100/7",        1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[1]  = '{"div -7/2",          1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  33};
        vecs[2]  = '{"divu fff9/2",       1'b0, 32'hFFFFFFF9,  32'd2,         32'd1,         32'h7FFFFFFC,  33};
        vecs[3]  = '{"div 5/0",           1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFFFFFF,  1};
        vecs[4]  = '{"divu 5/0",          1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFFFFFF,  1};
        vecs[5]  = '{"div min/-1",        1'b1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  33};
        vecs[6]  = '{"divu min/ffff",     1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         33};
        vecs[7]  = '{"div 7/-2",          1'b1, 32'd7,         32'hFFFFFFFE,  32'd1,         32'hFFFFFFFD,  33};
        vecs[8]  = '{"div -7/-2",         1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'hFFFFFFFF,  32'd3,         33};
        vecs[9]  = '{"div -100/7",        1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  32'hFFFFFFF2,  33};
        vecs[10] = '{"divu ffff/1",       1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,         32'hFFFFFFFF,  33};
        vecs[11] = '{"divu 3/10",         1'b0, 32'd3,         32'd10,        32'd3,         32'd0,         33};
        vecs[12] = '{"divu 9/3",          1'b0, 32'd9,         32'd3,         32'd0,         32'd3,         33};

        rst        = 1'b1;
        start      = 1'b1;
        signed_div = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        annul      = 1'b0;
        @(negedge clk);
        #1;
        chk("reset result", result, 64'd0);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset stall", 64'(stall_div), 64'd0);
        step();
        chk("reset held ready", 64'(ready), 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            run_div(vecs[i].name, vecs[i].sg, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].cyc, 1'b0);
            start = 1'b0;
            step();
            chk({vecs[i].name, " ready pulse end"}, 64'(ready), 64'd0);
        end
        held = {32'd0, 32'd3};

        // annul at cycle 10 of 100/7
        signed_div = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        start      = 1'b1;
        #1;
        rdy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ready) rdy_cnt++;
        end
        annul = 1'b1;
        #1;
        chk("annul stall", 64'(stall_div), 64'd0);
        step();
        start = 1'b0;
        annul = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (ready) rdy_cnt++;
            step();
        end
        chk("annul ready pulses", 64'(rdy_cnt), 64'd0);
        chk("annul result held", result, held);
        run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33, 1'b0);
        start = 1'b0;
        step();

        // annul together with start in IDLE
        signed_div = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        start      = 1'b1;
        annul      = 1'b1;
        #1;
        chk("annul+start stall", 64'(stall_div), 64'd0);
        rdy_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (ready) rdy_cnt++;
        end
        chk("annul+start no ready", 64'(rdy_cnt), 64'd0);
        annul = 1'b0;
        start = 1'b0;
        step();

        // reset at cycle 15 of a divide
        opa   = 32'd100;
        opb   = 32'd7;
        start = 1'b1;
        #1;
        rdy_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (ready) rdy_cnt++;
        end
        rst = 1'b1;
        #1;
        chk("midop rst result", result, 64'd0);
        chk("midop rst ready", 64'(ready), 64'd0);
        chk("midop rst stall", 64'(stall_div), 64'd0);
        chk("midop no ready before rst", 64'(rdy_cnt), 64'd0);
        start = 1'b0;
        step();
        rst = 1'b0;
        step();

        // back-to-back divides separated by one DONE cycle
        run_div("b2b first 100/7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
        run_div("b2b second -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1);
        start = 1'b0;
        step();
        chk("b2b ready pulse end", 64'(ready), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
